// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier and the
// datapath blocks that reuse its default operand width.
package seq_multiplier_pkg;

    // Default operand width used across the datapath.
    localparam int DEFAULT_WIDTH = 8;

    // Controller state encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : seq_multiplier_pkg

// File: rtl/seq_multiplier_twos_abs.sv
// Combinational magnitude of a WIDTH-bit operand. When is_signed is set the
// value is read as two's complement. The most negative value maps to
// 2^(WIDTH-1), which still fits as a WIDTH-bit unsigned result.
module twos_abs #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic             is_signed,
    output logic [WIDTH-1:0] abs_value
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Negate only negative two's-complement inputs; pass everything else through.
    always_comb begin
        abs_value = value;
        if (is_signed && value[WIDTH-1]) begin
            abs_value = ~value + ONE;
        end else begin
            abs_value = value;
        end
    end

endmodule : twos_abs

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one partial product per clock, WIDTH-bit
// operands, 2*WIDTH-bit product, signed or unsigned mode selected per request.
// Signed operands are reduced to magnitudes at acceptance and the sign is
// reapplied to the final accumulator, so the datapath is purely unsigned.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] PROD_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

    // Controller
    state_t                state_r;
    state_t                state_s;
    logic                  accept_s;
    logic                  last_s;
    logic                  busy_r;
    logic                  ready_r;
    logic                  done_r;

    // Latched operands and iteration state
    logic [WIDTH-1:0]      mcand_r;
    logic [WIDTH-1:0]      mplier_r;
    logic                  neg_r;
    logic [2*WIDTH-1:0]    acc_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [2*WIDTH-1:0]    product_r;

    // Operand preparation and per-step arithmetic
    logic [WIDTH-1:0]      abs_m_s;
    logic [WIDTH-1:0]      abs_q_s;
    logic                  neg_s;
    logic [WIDTH:0]        addend_s;
    logic [WIDTH:0]        sum_s;
    logic [2*WIDTH-1:0]    acc_step_s;
    logic [2*WIDTH-1:0]    final_s;

    // The accumulator LSB is shifted out on every step and never needed again.
    logic                  shift_out_unused_s;

    assign shift_out_unused_s = acc_r[0];

    assign busy    = busy_r;
    assign ready   = ready_r;
    assign done    = done_r;
    assign product = product_r;

    twos_abs #(
        .WIDTH     (WIDTH)
    ) u_abs_m (
        .value     (m),
        .is_signed (signed_mode),
        .abs_value (abs_m_s)
    );

    twos_abs #(
        .WIDTH     (WIDTH)
    ) u_abs_q (
        .value     (q),
        .is_signed (signed_mode),
        .abs_value (abs_q_s)
    );

    // Result sign: only meaningful in signed mode, where it is the XOR of the operand signs.
    always_comb begin
        neg_s = 1'b0;
        if (signed_mode) begin
            neg_s = m[WIDTH-1] ^ q[WIDTH-1];
        end else begin
            neg_s = 1'b0;
        end
    end

    // One shift-add step: conditionally add the multiplicand into the upper half, then shift right with carry.
    always_comb begin
        addend_s = {(WIDTH+1){1'b0}};
        if (mplier_r[0]) begin
            addend_s = {1'b0, mcand_r};
        end else begin
            addend_s = {(WIDTH+1){1'b0}};
        end
        sum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + addend_s;
        acc_step_s = {sum_s, acc_r[WIDTH-1:1]};
        final_s    = acc_step_s;
        if (neg_r) begin
            final_s = ~acc_step_s + PROD_ONE;
        end else begin
            final_s = acc_step_s;
        end
    end

    // Next-state logic; a request is taken only in IDLE or DONE, which lets DONE chain straight into RUN.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = (cnt_r == LAST_CNT);
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = RUN;
                end else begin
                    state_s  = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = RUN;
                end else begin
                    state_s  = IDLE;
                end
            end
            default: begin
                accept_s = 1'b0;
                state_s  = IDLE;
            end
        endcase
    end

    // State register with status outputs registered from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN);
            ready_r <= (state_s != RUN);
            done_r  <= (state_s == DONE);
        end
    end

    // Operand latch at acceptance, iteration while running, product capture on the last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_r   <= {WIDTH{1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            neg_r     <= 1'b0;
            acc_r     <= {(2*WIDTH){1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            product_r <= {(2*WIDTH){1'b0}};
        end else if (accept_s) begin
            mcand_r   <= abs_m_s;
            mplier_r  <= abs_q_s;
            neg_r     <= neg_s;
            acc_r     <= {(2*WIDTH){1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            product_r <= product_r;
        end else if (state_r == RUN) begin
            mcand_r   <= mcand_r;
            mplier_r  <= {1'b0, mplier_r[WIDTH-1:1]};
            neg_r     <= neg_r;
            acc_r     <= acc_step_s;
            cnt_r     <= cnt_r + CNT_ONE;
            if (last_s) begin
                product_r <= final_s;
            end else begin
                product_r <= product_r;
            end
        end else begin
            mcand_r   <= mcand_r;
            mplier_r  <= mplier_r;
            neg_r     <= neg_r;
            acc_r     <= acc_r;
            cnt_r     <= cnt_r;
            product_r <= product_r;
        end
    end

endmodule : seq_multiplier
